// File: rtl/coin_pay_fsm.sv
// Payer-side driver for the single-coin vending block: sends a programmed number of
// spaced coin pulses, counts the colas that come back, then reports done and a count mismatch.
module coin_pay_fsm #(
   parameter int COIN_W = 4,
   parameter int GAP    = 4,
   parameter int PRICE  = 3
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              pay_req,
   input  logic [COIN_W-1:0] pay_num,
   input  logic              pi_cola,
   output logic              po_money,
   output logic              pay_busy,
   output logic              pay_done,
   output logic [COIN_W-1:0] cola_cnt,
   output logic              cola_err
);

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_SEND  = 5'b00010,
      S_GAP   = 5'b00100,
      S_DRAIN = 5'b01000,
      S_DONE  = 5'b10000
   } state_t;

   // GAP state lasts GAP-1 cycles; the counter starts at 0 on entry.
   localparam logic [3:0] GAP_LAST = 4'(GAP - 2);

   state_t            state;
   logic [COIN_W-1:0] rem;
   logic [COIN_W-1:0] num_lat;
   logic [3:0]        gap_cnt;
   logic [COIN_W-1:0] cnt_next;
   logic [COIN_W-1:0] quota;

   always_comb begin
      cnt_next = cola_cnt;
      if (pay_busy && pi_cola && (cola_cnt != '1))
         cnt_next = cola_cnt + 1'b1;
      quota = COIN_W'(int'(num_lat) / PRICE);
   end

   // NOTE: all state and outputs update with non-blocking assignments so every
   // branch below sees the pre-edge values of the registers it reads.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= S_IDLE;
         rem      <= '0;
         num_lat  <= '0;
         gap_cnt  <= '0;
         po_money <= 1'b0;
         pay_busy <= 1'b0;
         pay_done <= 1'b0;
         cola_cnt <= '0;
         cola_err <= 1'b0;
      end else begin
         po_money <= 1'b0;
         pay_done <= 1'b0;
         cola_cnt <= cnt_next;
         case (state)
            S_IDLE: begin
               if (pay_req) begin
                  num_lat  <= pay_num;
                  cola_cnt <= '0;
                  cola_err <= 1'b0;
                  pay_busy <= 1'b1;
                  if (pay_num != '0) begin
                     rem      <= pay_num;
                     po_money <= 1'b1;
                     state    <= S_SEND;
                  end else begin
                     pay_done <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_SEND: begin
               rem     <= rem - 1'b1;
               gap_cnt <= '0;
               state   <= (rem != COIN_W'(1)) ? S_GAP : S_DRAIN;
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  po_money <= 1'b1;
                  state    <= S_SEND;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               // Two cycles let the vending block's registered cola reply land.
               if (gap_cnt == 4'd1) begin
                  pay_done <= 1'b1;
                  cola_err <= (cnt_next != quota);
                  state    <= S_DONE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_DONE: begin
               pay_busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               pay_busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coin_pay_fsm.sv
// Randomized self-checking bench for coin_pay_fsm with a small vending-block model
// and an arithmetic timing model of the payer side.
module tb_coin_pay_fsm;

   localparam int COIN_W = 4;
   localparam int GAP    = 4;
   localparam int PRICE  = 3;

   logic              sys_clk;
   logic              sys_rst;
   logic              pay_req;
   logic [COIN_W-1:0] pay_num;
   logic              pi_cola;
   logic              po_money;
   logic              pay_busy;
   logic              pay_done;
   logic [COIN_W-1:0] cola_cnt;
   logic              cola_err;

   int errors = 0;
   int checks = 0;
   int last_cnt = 0;

   coin_pay_fsm #(.COIN_W(COIN_W), .GAP(GAP), .PRICE(PRICE)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .pay_req  (pay_req),
      .pay_num  (pay_num),
      .pi_cola  (pi_cola),
      .po_money (po_money),
      .pay_busy (pay_busy),
      .pay_done (pay_done),
      .cola_cnt (cola_cnt),
      .cola_err (cola_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Drives one transaction from an IDLE cycle. mode 0: vending model answers,
   // mode 1: pi_cola held low, mode 2: random pi_cola noise.
   task automatic run_txn(input int num, input int mode, input bit interfere, input bit hold);
      int  done_cyc;
      int  last_pulse;
      int  cnt;
      int  err_cnt;
      int  coins;
      bit  pend;
      bit  drv;
      bit  exp_money;
      done_cyc   = (num == 0) ? 1 : 1 + (num - 1) * GAP + 3;
      last_pulse = 1 + (num - 1) * GAP;
      cnt = 0; err_cnt = 0; coins = 0; pend = 1'b0; drv = 1'b0;
      pay_req = 1'b1;
      pay_num = 4'(num);
      pi_cola = 1'b0;
      for (int n = 1; n <= done_cyc + 1; n++) begin
         @(posedge sys_clk); #1;
         if (drv && (n - 1) >= 1 && (n - 1) <= done_cyc && cnt < 15) cnt++;
         if (n == done_cyc) err_cnt = cnt;
         exp_money = (num != 0) && (n <= last_pulse) && ((n - 1) % GAP == 0);
         check("po_money", int'(po_money), int'(exp_money));
         check("pay_done", int'(pay_done), int'(n == done_cyc));
         check("pay_busy", int'(pay_busy), int'(n <= done_cyc));
         check("cola_cnt", int'(cola_cnt), cnt);
         check("cola_err", int'(cola_err), (n >= done_cyc) ? int'(err_cnt != num / PRICE) : 0);
         case (mode)
            0: begin
               drv  = pend;
               pend = 1'b0;
               if (po_money) begin
                  coins++;
                  if (coins == PRICE) begin
                     pend  = 1'b1;
                     coins = 0;
                  end
               end
            end
            1: drv = 1'b0;
            default: drv = 1'($urandom_range(0, 1));
         endcase
         pi_cola = drv;
         pay_num = 4'($urandom_range(0, 15));
         pay_req = (interfere && n >= 4 && n <= done_cyc) || (hold && n >= done_cyc);
         if (interfere && n >= 4) pay_num = 4'd9;
      end
      last_cnt = cnt;
   endtask

   task automatic idle_gap(input int k);
      pay_req = 1'b0;
      for (int i = 0; i < k; i++) begin
         pi_cola = 1'($urandom_range(0, 1));
         @(posedge sys_clk); #1;
         check("idle_cnt", int'(cola_cnt), last_cnt);
         check("idle_busy", int'(pay_busy), 0);
         check("idle_money", int'(po_money), 0);
      end
      pi_cola = 1'b0;
   endtask

   task automatic reset_mid;
      pay_req = 1'b1;
      pay_num = 4'd5;
      pi_cola = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         @(posedge sys_clk); #1;
         pay_req = 1'b0;
         check("rst_pre_money", int'(po_money), int'(n == 1 || n == 5));
      end
      sys_rst = 1'b1;
      #1;
      check("rst_async_busy", int'(pay_busy), 0);
      check("rst_async_money", int'(po_money), 0);
      check("rst_async_done", int'(pay_done), 0);
      check("rst_async_cnt", int'(cola_cnt), 0);
      check("rst_async_err", int'(cola_err), 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge sys_clk); #1;
         check("rst_hold_money", int'(po_money), 0);
         check("rst_hold_done", int'(pay_done), 0);
      end
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;
      check("rst_idle_busy", int'(pay_busy), 0);
      check("rst_idle_money", int'(po_money), 0);
      last_cnt = 0;
   endtask

   initial begin
      sys_rst = 1'b1;
      pay_req = 1'b0;
      pay_num = '0;
      pi_cola = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      check("reset_money", int'(po_money), 0);
      check("reset_busy", int'(pay_busy), 0);
      check("reset_done", int'(pay_done), 0);
      check("reset_cnt", int'(cola_cnt), 0);
      check("reset_err", int'(cola_err), 0);
      sys_rst = 1'b0;
      @(posedge sys_clk); #1;

      run_txn(3, 0, 1'b0, 1'b0);
      run_txn(7, 0, 1'b0, 1'b0);
      run_txn(0, 0, 1'b0, 1'b0);
      run_txn(3, 1, 1'b0, 1'b0);
      run_txn(3, 0, 1'b1, 1'b0);
      run_txn(3, 0, 1'b0, 1'b1);
      run_txn(2, 2, 1'b0, 1'b0);
      idle_gap(3);
      run_txn(15, 2, 1'b1, 1'b0);
      reset_mid();
      run_txn(3, 0, 1'b0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         int  num;
         int  mode;
         bit  intf;
         bit  hold;
         num  = $urandom_range(0, 15);
         mode = $urandom_range(0, 2);
         intf = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 3) == 0);
         run_txn(num, mode, intf, hold);
         if (!hold) idle_gap($urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coin_pay_fsm.md
Name: coin_pay_fsm

Overview:
Payer-side driver for the single-coin vending FSM. On request it emits a programmed number of one-cycle coin pulses at a fixed spacing on po_money, which drives the vending block's coin input. It counts cola pulses returned by the vending block, then reports completion and flags a cola-count mismatch. Used as the stimulus/master end of the vending interface in board demos and benches.

Parameters:
COIN_W, 4, width of the coin-count request and the cola counter.
GAP, 4, cycles from one po_money rising edge to the next; legal range is 2 to 15.
PRICE, 3, coins per cola; used only for the mismatch check.

Ports:
sys_clk  in  1  system clock, rising edge.
sys_rst  in  1  asynchronous, active-high reset.
pay_req  in  1  start request; sampled only in IDLE.
pay_num  in  COIN_W  number of coins to send; latched when the request is accepted.
pi_cola  in  1  one-cycle cola pulse from the vending block.
po_money  out  1  one-cycle coin pulse to the vending block.
pay_busy  out  1  high whenever the state is not IDLE.
pay_done  out  1  one-cycle completion pulse.
cola_cnt  out  COIN_W  colas received in the current or last transaction.
cola_err  out  1  mismatch flag; valid from the pay_done cycle until the next accept.

Behaviour:
- One clock domain. Reset is asynchronous and active-high, named sys_rst.
- All outputs are registered.
- Reset values: po_money=0, pay_busy=0, pay_done=0, cola_cnt=0, cola_err=0. State resets to IDLE. Internal counters reset to 0.
- States: IDLE, SEND, GAP, DRAIN, DONE. Encoding is one-hot; any illegal state returns to IDLE.
- Cycle numbering: the accepting clock edge is edge 0, and cycle n follows edge n.
- IDLE, pay_req=1 with pay_num!=0:
  - Latch pay_num into the remaining-coin counter.
  - Clear cola_cnt and cola_err.
  - Go to SEND. po_money is high in cycle 1.
- IDLE, pay_req=1 with pay_num=0:
  - Clear cola_cnt and cola_err.
  - Go straight to DONE, so pay_done=1 in cycle 1 with no pulses.
- SEND: po_money is high for exactly one cycle and the remaining-coin counter decrements.
  - If coins remain, go to GAP.
  - Otherwise go to DRAIN.
- GAP: hold for GAP-1 cycles with po_money=0, then SEND. Coin pulses therefore land in cycles 1, 1+GAP, 1+2*GAP, and so on.
- DRAIN: 2 cycles after the last pulse, so the registered cola response (1 cycle after the last coin) is captured. Then go to DONE.
- DONE: pay_done=1 for one cycle. Return to IDLE in the next cycle.
  - If the last pulse is in cycle L, pay_done is in cycle L+3.
  - pay_busy is high from cycle 1 through the pay_done cycle.
- cola_cnt:
  - Increments on pi_cola=1 only while pay_busy=1; pi_cola in IDLE is ignored.
  - Saturates at all ones.
  - Holds its value after DONE until the next accept.
- cola_err is registered in the DONE cycle as (cola_cnt after that cycle's update) != (latched pay_num / PRICE), using integer division. It holds until the next accept clears it.
- pay_req while busy is ignored and never queued. pay_num changes after accept have no effect.
- A pay_req held high in the DONE cycle is not accepted. A pay_req still high in the following IDLE cycle starts a new transaction.
- sys_rst mid-transaction: immediately forces reset values, including dropping any in-flight po_money. No done pulse is generated.

Test Plan:
- pay_num=3, default params, bench vending model connected: po_money high in cycles 1, 5 and 9; pi_cola in cycle 10; pay_done in cycle 12; cola_cnt=1, cola_err=0; pay_busy low from cycle 13.
- pay_num=7 with the vending model: 7 pulses at cycles 1, 5, …, 25; 2 colas; pay_done in cycle 28; cola_cnt=2, cola_err=0.
- pay_num=0: pay_done in cycle 1, no po_money pulse, cola_cnt=0, cola_err=0.
- pay_num=3 with pi_cola held low: pay_done in cycle 12, cola_cnt=0, cola_err=1.
- pay_num=3, then pay_req=1 with pay_num=9 at cycle 4: ignored; still exactly 3 pulses, done in cycle 12.
- pay_num=5, assert sys_rst in cycle 6, just after the 2nd pulse: all outputs 0 immediately and no further pulses. A new pay_num=3 request after release completes normally (done 12 cycles after its accept).
